// File: rtl/input_router_pkg.sv
// Shared definitions for the input-router address bundle: fetch FSM states and
// default window geometry.
package input_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam int DEF_ADDR_LENGTH = 9;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_KERNEL_SIZE = 3;

endpackage

// File: rtl/window_fetcher_stats.sv
// Saturating window/stall counters for window_fetcher; only instantiated when
// WINDOW_FETCHER_STATS_EN is defined.
module window_fetcher_stats (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_reg_clear,
  input  logic        i_win_done,
  input  logic        i_stall,
  output logic [31:0] o_window_count,
  output logic [31:0] o_stall_count
);

  logic [31:0] r_window_count;
  logic [31:0] r_stall_count;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      r_window_count <= 32'd0;
      r_stall_count  <= 32'd0;
    end else begin
      if (i_win_done && (r_window_count != 32'hFFFF_FFFF)) begin
        r_window_count <= r_window_count + 32'd1;
      end
      if (i_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign o_window_count = r_window_count;
  assign o_stall_count  = r_stall_count;

endmodule

// File: rtl/window_fetcher.sv
// Fetches the nine addresses of one bundle from the activation buffer and presents
// the assembled 3x3 window downstream. Optional counters: WINDOW_FETCHER_STATS_EN.
module window_fetcher
  import input_router_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int ADDR_LENGTH = DEF_ADDR_LENGTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ROW_COUNT   = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_nrst,
  input  logic                                    i_reg_clear,
  input  logic                                    i_valid,
  input  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]  i_addr,
  input  logic [ADDR_WIDTH-1:0]                   i_o_x,
  input  logic [ADDR_WIDTH-1:0]                   i_o_y,
  input  logic [ROW_COUNT-1:0]                    i_row_id,
  output logic                                    o_ready,
  output logic                                    o_rd_en,
  output logic [ADDR_WIDTH-1:0]                   o_rd_addr,
  input  logic [DATA_WIDTH-1:0]                   i_rd_data,
  output logic                                    o_valid,
  output logic [0:ADDR_LENGTH-1][DATA_WIDTH-1:0]  o_window,
  output logic [ADDR_WIDTH-1:0]                   o_o_x,
  output logic [ADDR_WIDTH-1:0]                   o_o_y,
  output logic [ROW_COUNT-1:0]                    o_row_id,
  input  logic                                    i_ready
`ifdef WINDOW_FETCHER_STATS_EN
  ,
  output logic [31:0]                             o_window_count,
  output logic [31:0]                             o_stall_count
`endif
);

  localparam int             K_W    = $clog2(ADDR_LENGTH);
  localparam logic [K_W-1:0] K_LAST = K_W'(ADDR_LENGTH - 1);

  fetch_state_t                                 r_state;
  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]       r_addr;
  logic [ADDR_WIDTH-1:0]                        r_o_x;
  logic [ADDR_WIDTH-1:0]                        r_o_y;
  logic [ROW_COUNT-1:0]                         r_row_id;
  logic [K_W-1:0]                               r_k;
  logic [K_W-1:0]                               r_k_prev;
  logic                                         r_rd_pending;
  logic [0:ADDR_LENGTH-1][DATA_WIDTH-1:0]       r_window;

  logic w_rd_en;
  logic w_hold;

  assign w_rd_en = (r_state == FETCH);
  assign w_hold  = (r_state == HOLD);

  // Control FSM, bundle latch and read index.
  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_o_x    <= {ADDR_WIDTH{1'b0}};
      r_o_y    <= {ADDR_WIDTH{1'b0}};
      r_row_id <= {ROW_COUNT{1'b0}};
      r_k      <= {K_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_addr   <= i_addr;
            r_o_x    <= i_o_x;
            r_o_y    <= i_o_y;
            r_row_id <= i_row_id;
            r_k      <= {K_W{1'b0}};
            r_state  <= FETCH;
          end
        end
        FETCH: begin
          if (r_k == K_LAST) begin
            r_k     <= {K_W{1'b0}};
            r_state <= DRAIN;
          end else begin
            r_k <= r_k + {{(K_W-1){1'b0}}, 1'b1};
          end
        end
        DRAIN: r_state <= HOLD;
        HOLD: begin
          if (i_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data lands one cycle after the strobe; the index travels with it so the
  // last element is captured during DRAIN. Reset drops anything still in flight.
  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      r_rd_pending <= 1'b0;
      r_k_prev     <= {K_W{1'b0}};
      r_window     <= '0;
    end else begin
      r_rd_pending <= w_rd_en;
      r_k_prev     <= r_k;
      if (r_rd_pending) begin
        r_window[r_k_prev] <= i_rd_data;
      end
    end
  end

  assign o_ready   = (r_state == IDLE);
  assign o_rd_en   = w_rd_en;
  assign o_rd_addr = w_rd_en ? r_addr[r_k] : {ADDR_WIDTH{1'b0}};
  assign o_valid   = w_hold;
  assign o_window  = w_hold ? r_window : '0;
  assign o_o_x     = w_hold ? r_o_x : {ADDR_WIDTH{1'b0}};
  assign o_o_y     = w_hold ? r_o_y : {ADDR_WIDTH{1'b0}};
  assign o_row_id  = w_hold ? r_row_id : {ROW_COUNT{1'b0}};

`ifdef WINDOW_FETCHER_STATS_EN
  window_fetcher_stats u_stats (
    .i_clk          (i_clk),
    .i_nrst         (i_nrst),
    .i_reg_clear    (i_reg_clear),
    .i_win_done     (w_hold && i_ready),
    .i_stall        (w_hold && !i_ready),
    .o_window_count (o_window_count),
    .o_stall_count  (o_stall_count)
  );
`endif

endmodule

// File: tb/tb_window_fetcher.sv
// Directed self-checking bench for window_fetcher; stats checks are compiled in
// when WINDOW_FETCHER_STATS_EN is defined.
module tb_window_fetcher;

  logic                i_clk = 1'b0;
  logic                i_nrst;
  logic                i_reg_clear;
  logic                i_valid;
  logic [0:8][5:0]     i_addr;
  logic [5:0]          i_o_x;
  logic [5:0]          i_o_y;
  logic [3:0]          i_row_id;
  logic                o_ready;
  logic                o_rd_en;
  logic [5:0]          o_rd_addr;
  logic [7:0]          i_rd_data;
  logic                o_valid;
  logic [0:8][7:0]     o_window;
  logic [5:0]          o_o_x;
  logic [5:0]          o_o_y;
  logic [3:0]          o_row_id;
  logic                i_ready;
`ifdef WINDOW_FETCHER_STATS_EN
  logic [31:0]         o_window_count;
  logic [31:0]         o_stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] r_mem_q = 8'hEE;

  window_fetcher dut (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_reg_clear (i_reg_clear),
    .i_valid     (i_valid),
    .i_addr      (i_addr),
    .i_o_x       (i_o_x),
    .i_o_y       (i_o_y),
    .i_row_id    (i_row_id),
    .o_ready     (o_ready),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_valid     (o_valid),
    .o_window    (o_window),
    .o_o_x       (o_o_x),
    .o_o_y       (o_o_y),
    .o_row_id    (o_row_id),
    .i_ready     (i_ready)
`ifdef WINDOW_FETCHER_STATS_EN
    ,
    .o_window_count (o_window_count),
    .o_stall_count  (o_stall_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Buffer model: word[a] = a + 16, one cycle after the strobe; junk otherwise.
  always @(posedge i_clk) r_mem_q <= o_rd_en ? ({2'b00, o_rd_addr} + 8'd16) : 8'hEE;
  assign i_rd_data = r_mem_q;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  function automatic logic [0:8][7:0] win_of(input logic [0:8][5:0] a);
    logic [0:8][7:0] w;
    for (int k = 0; k < 9; k++) w[k] = {2'b00, a[k]} + 8'd16;
    return w;
  endfunction

  // Called in cycle T (IDLE); returns in T+1.
  task automatic accept(input logic [0:8][5:0] a, input logic [5:0] x, input logic [5:0] y,
                        input logic [3:0] row, input bit keep);
    check_eq("accept_ready", o_ready, 1'b1);
    i_valid = 1'b1; i_addr = a; i_o_x = x; i_o_y = y; i_row_id = row;
    tick();
    if (!keep) i_valid = 1'b0;
  endtask

  // Called in T+1; returns in T+11. Optionally scrambles the bundle inputs.
  task automatic expect_reads(input logic [0:8][5:0] a, input bit scramble);
    for (int n = 0; n < 9; n++) begin
      check_eq("rd_en", o_rd_en, 1'b1);
      check_eq("rd_addr", o_rd_addr, a[n]);
      check_eq("busy_ready", o_ready, 1'b0);
      check_eq("busy_valid", o_valid, 1'b0);
      if (scramble) begin
        i_addr = {9{6'(40 + n)}};
        i_o_x  = 6'(n);
      end
      tick();
    end
    check_eq("drain_rd_en", o_rd_en, 1'b0);
    check_eq("drain_rd_addr", o_rd_addr, 6'd0);
    check_eq("drain_valid", o_valid, 1'b0);
    tick();
  endtask

  logic [0:8][5:0] a_seq, a_rev, a_b, a_nc;
  logic [0:8][7:0] w_exp;
  int valid_seen;

  initial begin
    i_nrst = 1'b0; i_reg_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_addr = '0; i_o_x = 6'd0; i_o_y = 6'd0; i_row_id = 4'd0;
    for (int k = 0; k < 9; k++) begin
      a_seq[k] = 6'(k);
      a_rev[k] = 6'(8 - k);
      a_b[k]   = 6'(20 + 2 * k);
    end
    a_nc = {6'd63, 6'd0, 6'd31, 6'd7, 6'd7, 6'd7, 6'd1, 6'd2, 6'd3};
    tick(); tick();

    // Reset state
    check_eq("rst_ready", o_ready, 1'b1);
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_rd_en", o_rd_en, 1'b0);
    check_eq("rst_rd_addr", o_rd_addr, 6'd0);
    check_eq("rst_window", o_window, 72'd0);
    check_eq("rst_row", o_row_id, 4'd0);
`ifdef WINDOW_FETCHER_STATS_EN
    check_eq("rst_wcount", o_window_count, 32'd0);
    check_eq("rst_scount", o_stall_count, 32'd0);
`endif
    i_nrst = 1'b1;
    tick();

    // Single bundle, addresses 0..8
    accept(a_seq, 6'd5, 6'd9, 4'd3, 1'b0);
    expect_reads(a_seq, 1'b0);
    w_exp = {8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
    check_eq("t1_valid", o_valid, 1'b1);
    check_eq("t1_window", o_window, w_exp);
    check_eq("t1_x", o_o_x, 6'd5);
    check_eq("t1_y", o_o_y, 6'd9);
    check_eq("t1_row", o_row_id, 4'd3);
    tick();
    check_eq("t1_valid_drop", o_valid, 1'b0);
    check_eq("t1_window_zero", o_window, 72'd0);
    check_eq("t1_ready_back", o_ready, 1'b1);

    // Clear in IDLE, then back-pressure for 5 cycles
    i_reg_clear = 1'b1; tick(); i_reg_clear = 1'b0;
    check_eq("clr_ready", o_ready, 1'b1);
    i_ready = 1'b0;
    accept(a_rev, 6'd33, 6'd2, 4'd9, 1'b0);
    expect_reads(a_rev, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_valid", o_valid, 1'b1);
      check_eq("bp_window", o_window, win_of(a_rev));
      check_eq("bp_x", o_o_x, 6'd33);
      tick();
    end
`ifdef WINDOW_FETCHER_STATS_EN
    check_eq("bp_stall_count", o_stall_count, 32'd5);
    check_eq("bp_wcount_held", o_window_count, 32'd0);
`endif
    check_eq("bp_still_valid", o_valid, 1'b1);
    i_ready = 1'b1;
    tick();
    check_eq("bp_release_valid", o_valid, 1'b0);
`ifdef WINDOW_FETCHER_STATS_EN
    check_eq("bp_wcount", o_window_count, 32'd1);
    check_eq("bp_stall_final", o_stall_count, 32'd5);
`endif

    // i_valid held high with changing inputs during fetch
    accept(a_seq, 6'd7, 6'd8, 4'd1, 1'b1);
    expect_reads(a_seq, 1'b1);
    i_addr = a_b; i_o_x = 6'd44; i_o_y = 6'd45; i_row_id = 4'd12;
    check_eq("hv_valid", o_valid, 1'b1);
    check_eq("hv_window", o_window, win_of(a_seq));
    check_eq("hv_x", o_o_x, 6'd7);
    tick();
    check_eq("hv_second_ready", o_ready, 1'b1);
    check_eq("hv_valid_drop", o_valid, 1'b0);
    tick();
    i_valid = 1'b0;
    expect_reads(a_b, 1'b0);
    check_eq("hv2_window", o_window, win_of(a_b));
    check_eq("hv2_x", o_o_x, 6'd44);
    check_eq("hv2_y", o_o_y, 6'd45);
    check_eq("hv2_row", o_row_id, 4'd12);
    tick();

    // Non-contiguous and repeated addresses
    accept(a_nc, 6'd1, 6'd63, 4'd15, 1'b0);
    expect_reads(a_nc, 1'b0);
    w_exp = {8'd79, 8'd16, 8'd47, 8'd23, 8'd23, 8'd23, 8'd17, 8'd18, 8'd19};
    check_eq("nc_window", o_window, w_exp);
    check_eq("nc_row", o_row_id, 4'd15);
    tick();

    // Reset mid-fetch at T+5
    accept(a_rev, 6'd3, 6'd3, 4'd2, 1'b0);
    tick(); tick(); tick(); tick();
    check_eq("mid_rd_en_before", o_rd_en, 1'b1);
    i_nrst = 1'b0;
    tick();
    check_eq("mid_rd_en", o_rd_en, 1'b0);
    check_eq("mid_ready", o_ready, 1'b1);
    i_nrst = 1'b1;
    valid_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_valid) valid_seen++;
      tick();
    end
    check_eq("mid_no_valid", valid_seen, 0);
`ifdef WINDOW_FETCHER_STATS_EN
    check_eq("mid_wcount_zero", o_window_count, 32'd0);
`endif
    accept(a_seq, 6'd10, 6'd11, 4'd5, 1'b0);
    expect_reads(a_seq, 1'b0);
    check_eq("post_rst_window", o_window, win_of(a_seq));
    tick();

    // Clear coincident with i_ready in HOLD
    accept(a_b, 6'd21, 6'd22, 4'd6, 1'b0);
    expect_reads(a_b, 1'b0);
    check_eq("clr_hold_valid", o_valid, 1'b1);
`ifdef WINDOW_FETCHER_STATS_EN
    check_eq("clr_wcount_before", o_window_count, 32'd1);
`endif
    i_reg_clear = 1'b1; i_ready = 1'b1;
    tick();
    i_reg_clear = 1'b0;
    check_eq("clr_valid", o_valid, 1'b0);
    check_eq("clr_idle", o_ready, 1'b1);
    check_eq("clr_window", o_window, 72'd0);
`ifdef WINDOW_FETCHER_STATS_EN
    check_eq("clr_wcount", o_window_count, 32'd0);
    check_eq("clr_scount", o_stall_count, 32'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
